// File: rtl/imm_ext_pkg.sv
// Shared types and encodings for the immediate-extension stage.
// Optional feature macro: IMM_EXT_RVC_EN (compressed-instruction immediates).
package imm_ext_pkg;

   // Immediate format reported alongside each extended immediate
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_ISH  = 3'd2,
      IMM_S    = 3'd3,
      IMM_B    = 3'd4,
      IMM_U    = 3'd5,
      IMM_J    = 3'd6,
      IMM_CI   = 3'd7
   } imm_type_e;

   // Major opcodes, inst[6:2]
   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_AMO       = 5'b01011;
   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_OP_32     = 5'b01110;
   localparam logic [4:0] OPC_OP_FP     = 5'b10100;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

   // funct3 values selecting the shift-immediate forms
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   // Compressed quadrants, inst[1:0]
   localparam logic [1:0] RVC_Q0 = 2'b00;
   localparam logic [1:0] RVC_Q1 = 2'b01;

   // Compressed funct3, inst[15:13]
   localparam logic [2:0] C_LW   = 3'b010;   // quadrant 0
   localparam logic [2:0] C_SW   = 3'b110;   // quadrant 0
   localparam logic [2:0] C_ADDI = 3'b000;   // quadrant 1
   localparam logic [2:0] C_LI   = 3'b010;   // quadrant 1
   localparam logic [2:0] C_LUI  = 3'b011;   // quadrant 1 (rd==x2 is C.ADDI16SP)
   localparam logic [2:0] C_J    = 3'b101;   // quadrant 1
   localparam logic [2:0] C_BEQZ = 3'b110;   // quadrant 1
   localparam logic [2:0] C_BNEZ = 3'b111;   // quadrant 1

   localparam logic [4:0] RVC_RD_SP = 5'd2;

   // True for the funct3 codes of the shift-immediate instructions
   function automatic logic is_shift_f3(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SRX);
   endfunction

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational immediate decoder: instruction word -> extended immediate,
// format and illegal flag. Compressed immediates decoded when IMM_EXT_RVC_EN
// is defined; otherwise every non-32-bit encoding is reported illegal.
module imm_ext_decode
   import imm_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);

   imm_type_e  type_sel;
   logic [4:0] opcode;
   logic [2:0] funct3;

   assign opcode   = inst[6:2];
   assign funct3   = inst[14:12];
   assign imm_type = type_sel;

   // Classify the encoding and build its extended immediate; all outputs defaulted first
   always_comb begin
      imm      = '0;
      type_sel = IMM_NONE;
      illegal  = 1'b1;
      if (inst[1:0] == 2'b11) begin
         case (opcode)
            OPC_LOAD, OPC_JALR: begin
               imm      = XLEN'($signed(inst[31:20]));
               type_sel = IMM_I;
               illegal  = 1'b0;
            end
            OPC_OP_IMM: begin
               if (is_shift_f3(funct3)) begin
                  type_sel = IMM_ISH;
                  if (XLEN == 64) begin
                     imm     = XLEN'(inst[25:20]);
                     illegal = 1'b0;
                  end else begin
                     // shamt[5] set is reserved when only 32 shift positions exist
                     imm     = XLEN'(inst[24:20]);
                     illegal = inst[25];
                  end
               end else begin
                  imm      = XLEN'($signed(inst[31:20]));
                  type_sel = IMM_I;
                  illegal  = 1'b0;
               end
            end
            OPC_OP_IMM_32: begin
               // Word-sized ops exist only on the 64-bit datapath
               if (XLEN == 64) begin
                  if (is_shift_f3(funct3)) begin
                     imm      = XLEN'(inst[24:20]);
                     type_sel = IMM_ISH;
                     illegal  = inst[25];
                  end else begin
                     imm      = XLEN'($signed(inst[31:20]));
                     type_sel = IMM_I;
                     illegal  = 1'b0;
                  end
               end
            end
            OPC_STORE: begin
               imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
               type_sel = IMM_S;
               illegal  = 1'b0;
            end
            OPC_BRANCH: begin
               imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
               type_sel = IMM_B;
               illegal  = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
               imm      = XLEN'($signed({inst[31:12], 12'b0}));
               type_sel = IMM_U;
               illegal  = 1'b0;
            end
            OPC_JAL: begin
               imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
               type_sel = IMM_J;
               illegal  = 1'b0;
            end
            OPC_OP, OPC_OP_32, OPC_SYSTEM, OPC_MISC_MEM, OPC_AMO, OPC_OP_FP: begin
               // Register/system forms: legal but carry no immediate
               illegal = 1'b0;
            end
            default: begin
               illegal = 1'b1;
            end
         endcase
      end else begin
`ifdef IMM_EXT_RVC_EN
         // Compressed encodings use only the low halfword
         case (inst[1:0])
            RVC_Q0: begin
               case (inst[15:13])
                  C_LW, C_SW: begin
                     imm      = XLEN'({inst[5], inst[12:10], inst[6], 2'b00});
                     type_sel = IMM_CI;
                     illegal  = 1'b0;
                  end
                  default: illegal = 1'b1;
               endcase
            end
            RVC_Q1: begin
               case (inst[15:13])
                  C_ADDI, C_LI: begin
                     imm      = XLEN'($signed({inst[12], inst[6:2]}));
                     type_sel = IMM_CI;
                     illegal  = 1'b0;
                  end
                  C_LUI: begin
                     // rd==x2 is the stack-adjust form, not handled here
                     if (inst[11:7] != RVC_RD_SP) begin
                        imm      = XLEN'($signed({inst[12], inst[6:2], 12'b0}));
                        type_sel = IMM_U;
                        illegal  = ({inst[12], inst[6:2]} == 6'd0);
                     end
                  end
                  C_J: begin
                     imm      = XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                               inst[2], inst[11], inst[5:3], 1'b0}));
                     type_sel = IMM_J;
                     illegal  = 1'b0;
                  end
                  C_BEQZ, C_BNEZ: begin
                     imm      = XLEN'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                                               inst[4:3], 1'b0}));
                     type_sel = IMM_B;
                     illegal  = 1'b0;
                  end
                  default: illegal = 1'b1;
               endcase
            end
            default: illegal = 1'b1;
         endcase
`else
         // Compressed encodings unsupported in this build
         imm      = '0;
         type_sel = IMM_NONE;
         illegal  = 1'b1;
`endif
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
// Decode happens on the input side; the main entry drives the outputs and the
// skid entry absorbs one transfer while the output is stalled, so in_ready can
// be a flop. Optional feature macro: IMM_EXT_RVC_EN (see imm_ext_decode).
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_type,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  dec_imm;
   logic [2:0]       dec_type;
   logic             dec_illegal;

   logic             main_valid_q,   main_valid_d;
   logic [XLEN-1:0]  main_imm_q,     main_imm_d;
   logic [2:0]       main_type_q,    main_type_d;
   logic             main_illegal_q, main_illegal_d;
   logic [TAG_W-1:0] main_tag_q,     main_tag_d;

   logic             skid_valid_q,   skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
   logic [2:0]       skid_type_q,    skid_type_d;
   logic             skid_illegal_q, skid_illegal_d;
   logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

   logic             in_ready_q,     in_ready_d;
   logic             in_fire;
   logic             out_fire;

   imm_ext_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .inst     (in_inst),
      .imm      (dec_imm),
      .imm_type (dec_type),
      .illegal  (dec_illegal)
   );

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = main_valid_q && out_ready;

   // Next-state of both entries: flush first, then fill/drain keeping FIFO order
   always_comb begin
      main_valid_d   = main_valid_q;
      main_imm_d     = main_imm_q;
      main_type_d    = main_type_q;
      main_illegal_d = main_illegal_q;
      main_tag_d     = main_tag_q;
      skid_valid_d   = skid_valid_q;
      skid_imm_d     = skid_imm_q;
      skid_type_d    = skid_type_q;
      skid_illegal_d = skid_illegal_q;
      skid_tag_d     = skid_tag_q;

      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || (out_fire && !skid_valid_q)) begin
         // Main is free (or leaving with nothing behind it): new input goes straight in
         main_valid_d = in_fire;
         if (in_fire) begin
            main_imm_d     = dec_imm;
            main_type_d    = dec_type;
            main_illegal_d = dec_illegal;
            main_tag_d     = in_tag;
         end
      end else if (out_fire) begin
         // Skid holds the older entry; in_ready was low so no input this cycle
         main_valid_d   = 1'b1;
         main_imm_d     = skid_imm_q;
         main_type_d    = skid_type_q;
         main_illegal_d = skid_illegal_q;
         main_tag_d     = skid_tag_q;
         skid_valid_d   = 1'b0;
      end else if (in_fire) begin
         // Output stalled: park the new input behind main
         skid_valid_d   = 1'b1;
         skid_imm_d     = dec_imm;
         skid_type_d    = dec_type;
         skid_illegal_d = dec_illegal;
         skid_tag_d     = in_tag;
      end

      in_ready_d = !skid_valid_d;
   end

   // Entry and ready flops; reset empties everything and clears the output data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q   <= 1'b0;
         main_imm_q     <= '0;
         main_type_q    <= IMM_NONE;
         main_illegal_q <= 1'b0;
         main_tag_q     <= '0;
         skid_valid_q   <= 1'b0;
         skid_imm_q     <= '0;
         skid_type_q    <= IMM_NONE;
         skid_illegal_q <= 1'b0;
         skid_tag_q     <= '0;
         in_ready_q     <= 1'b1;
      end else begin
         main_valid_q   <= main_valid_d;
         main_imm_q     <= main_imm_d;
         main_type_q    <= main_type_d;
         main_illegal_q <= main_illegal_d;
         main_tag_q     <= main_tag_d;
         skid_valid_q   <= skid_valid_d;
         skid_imm_q     <= skid_imm_d;
         skid_type_q    <= skid_type_d;
         skid_illegal_q <= skid_illegal_d;
         skid_tag_q     <= skid_tag_d;
         in_ready_q     <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign out_imm     = main_imm_q;
   assign out_type    = main_type_q;
   assign out_illegal = main_illegal_q;
   assign out_tag     = main_tag_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: a 32-bit and a 64-bit instance share the
// same stimulus; expected results are queued on accept and checked on output.
module tb_imm_ext_pipe;
   import imm_ext_pkg::*;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic        ill;
      logic [7:0]  tag;
      logic        chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_i;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [7:0]  in_tag;
   logic        out_ready;

   logic        r32_in_ready, r32_out_valid, r32_out_illegal;
   logic [31:0] r32_out_imm;
   logic [2:0]  r32_out_type;
   logic [7:0]  r32_out_tag;
   logic        r64_in_ready, r64_out_valid, r64_out_illegal;
   logic [63:0] r64_out_imm;
   logic [2:0]  r64_out_type;
   logic [7:0]  r64_out_tag;

   exp_t cur32, cur64;
   exp_t q32[$];
   exp_t q64[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(r32_in_ready), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_out_imm),
      .out_type(r32_out_type), .out_illegal(r32_out_illegal), .out_tag(r32_out_tag)
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(r64_in_ready), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_out_imm),
      .out_type(r64_out_type), .out_illegal(r64_out_illegal), .out_tag(r64_out_tag)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check32();
      exp_t e;
      int   n;
      n = q32.size();
      if (n == 0) begin
         check("x32_unexpected_output", 64'(n), 64'd1);
         return;
      end
      e = q32.pop_front();
      check("x32_tag", {56'b0, r32_out_tag}, {56'b0, e.tag});
      check("x32_illegal", {63'b0, r32_out_illegal}, {63'b0, e.ill});
      if (e.chk_data) begin
         check("x32_imm", {32'b0, r32_out_imm}, e.imm);
         check("x32_type", {61'b0, r32_out_type}, {61'b0, e.typ});
      end
      $display("x32 out tag=%h imm=%h type=%0d ill=%0d", r32_out_tag, r32_out_imm,
               r32_out_type, r32_out_illegal);
   endtask

   task automatic pop_check64();
      exp_t e;
      int   n;
      n = q64.size();
      if (n == 0) begin
         check("x64_unexpected_output", 64'(n), 64'd1);
         return;
      end
      e = q64.pop_front();
      check("x64_tag", {56'b0, r64_out_tag}, {56'b0, e.tag});
      check("x64_illegal", {63'b0, r64_out_illegal}, {63'b0, e.ill});
      check("x64_imm", r64_out_imm, e.imm);
      check("x64_type", {61'b0, r64_out_type}, {61'b0, e.typ});
      $display("x64 out tag=%h imm=%h type=%0d ill=%0d", r64_out_tag, r64_out_imm,
               r64_out_type, r64_out_illegal);
   endtask

   // Scoreboard: compare on output fire, enqueue on input accept, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         q32.delete();
         q64.delete();
      end else if (flush_i) begin
         q32.delete();
         q64.delete();
      end else begin
         if (r32_out_valid && out_ready) pop_check32();
         if (r64_out_valid && out_ready) pop_check64();
         if (in_valid && r32_in_ready) q32.push_back(cur32);
         if (in_valid && r64_in_ready) q64.push_back(cur64);
      end
   end

   // Present one instruction with its expected results for both widths
   task automatic set_in(input logic [31:0] inst, input logic [7:0] tag,
                         input logic [31:0] imm32, input logic [2:0] t32, input logic i32,
                         input logic c32,
                         input logic [63:0] imm64, input logic [2:0] t64, input logic i64);
      in_valid = 1'b1;
      in_inst  = inst;
      in_tag   = tag;
      cur32    = '{imm: {32'b0, imm32}, typ: t32, ill: i32, tag: tag, chk_data: c32};
      cur64    = '{imm: imm64, typ: t64, ill: i64, tag: tag, chk_data: 1'b1};
   endtask

   // Hold the current input until accepted; returns 1 time unit after the accepting edge
   task automatic wait_accept(input string w);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (r32_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check({"accept_", w}, {63'b0, ok}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Wait for the scoreboard to empty, bounded
   task automatic drain(input string w);
      for (int k = 0; k < 30; k++) begin
         if (q32.size() == 0 && q64.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check({"drain_", w}, 64'(q32.size() + q64.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      flush_i   = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      cur32     = '0;
      cur64     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid32", {63'b0, r32_out_valid}, 64'd0);
      check("rst_out_valid64", {63'b0, r64_out_valid}, 64'd0);
      check("rst_in_ready", {63'b0, r32_in_ready}, 64'd1);
      check("rst_out_imm", {32'b0, r32_out_imm}, 64'd0);
      check("rst_out_type", {61'b0, r32_out_type}, 64'd0);
      check("rst_out_illegal", {63'b0, r32_out_illegal}, 64'd0);
      check("rst_out_tag", {56'b0, r32_out_tag}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single addi: output valid one cycle after accept
      out_ready = 1'b1;
      set_in(32'hFFF00093, 8'h01, 32'hFFFFFFFF, IMM_I, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0);
      wait_accept("addi");
      in_valid = 1'b0;
      check("lat_out_valid", {63'b0, r32_out_valid}, 64'd1);
      check("lat_out_imm32", {32'b0, r32_out_imm}, 64'h00000000FFFFFFFF);
      check("lat_out_imm64", r64_out_imm, 64'hFFFFFFFFFFFFFFFF);
      drain("addi");

      // Back-to-back stream with downstream always ready: in_ready never drops
      set_in(32'hFE000EE3, 8'h02, 32'hFFFFFFFC, IMM_B, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFC, IMM_B, 1'b0);
      wait_accept("beq");
      check("stream_ready_beq", {63'b0, r32_in_ready}, 64'd1);
      set_in(32'h123450B7, 8'h03, 32'h12345000, IMM_U, 1'b0, 1'b1,
             64'h0000000012345000, IMM_U, 1'b0);
      wait_accept("lui");
      check("stream_ready_lui", {63'b0, r32_in_ready}, 64'd1);
      set_in(32'h03F09093, 8'h04, 32'h0, IMM_ISH, 1'b1, 1'b0,
             64'd63, IMM_ISH, 1'b0);
      wait_accept("slli63");
      set_in(32'h4030D093, 8'h05, 32'd3, IMM_ISH, 1'b0, 1'b1,
             64'd3, IMM_ISH, 1'b0);
      wait_accept("srai");
      set_in(32'hFE112E23, 8'h06, 32'hFFFFFFFC, IMM_S, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFC, IMM_S, 1'b0);
      wait_accept("sw");
      set_in(32'h008000EF, 8'h07, 32'd8, IMM_J, 1'b0, 1'b1,
             64'd8, IMM_J, 1'b0);
      wait_accept("jal");
      set_in(32'h002081B3, 8'h08, 32'd0, IMM_NONE, 1'b0, 1'b1,
             64'd0, IMM_NONE, 1'b0);
      wait_accept("add");
      set_in(32'h0000007F, 8'h09, 32'd0, IMM_NONE, 1'b1, 1'b1,
             64'd0, IMM_NONE, 1'b1);
      wait_accept("bad_opcode");
`ifdef IMM_EXT_RVC_EN
      set_in(32'h000050FD, 8'h0A, 32'hFFFFFFFF, IMM_CI, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_CI, 1'b0);
`else
      set_in(32'h000050FD, 8'h0A, 32'd0, IMM_NONE, 1'b1, 1'b1,
             64'd0, IMM_NONE, 1'b1);
`endif
      wait_accept("c_li");
      set_in(32'hFFF0809B, 8'h0B, 32'd0, IMM_NONE, 1'b1, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0);
      wait_accept("addiw");
      set_in(32'h800000B7, 8'h0C, 32'h80000000, IMM_U, 1'b0, 1'b1,
             64'hFFFFFFFF80000000, IMM_U, 1'b0);
      wait_accept("lui_neg");
      check("stream_ready_end", {63'b0, r32_in_ready}, 64'd1);
      in_valid = 1'b0;
      drain("stream");

      // Stall: 4 back-to-back inputs, downstream not ready for 3 cycles
      out_ready = 1'b0;
      set_in(32'hFFF00093, 8'h41, 32'hFFFFFFFF, IMM_I, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0);
      wait_accept("stall1");
      check("stall_ready_after1", {63'b0, r32_in_ready}, 64'd1);
      set_in(32'h123450B7, 8'h42, 32'h12345000, IMM_U, 1'b0, 1'b1,
             64'h0000000012345000, IMM_U, 1'b0);
      wait_accept("stall2");
      check("stall_ready_after2", {63'b0, r32_in_ready}, 64'd0);
      check("stall_out_valid", {63'b0, r32_out_valid}, 64'd1);
      set_in(32'hFE000EE3, 8'h43, 32'hFFFFFFFC, IMM_B, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFC, IMM_B, 1'b0);
      @(posedge clk);
      #1;
      check("stall_ready_held", {63'b0, r32_in_ready}, 64'd0);
      check("stall_head_tag", {56'b0, r32_out_tag}, 64'h41);
      out_ready = 1'b1;
      wait_accept("stall3");
      set_in(32'h008000EF, 8'h44, 32'd8, IMM_J, 1'b0, 1'b1,
             64'd8, IMM_J, 1'b0);
      wait_accept("stall4");
      in_valid = 1'b0;
      drain("stall");

      // Flush with both entries full; the presented input is dropped
      out_ready = 1'b0;
      set_in(32'hFFF00093, 8'h51, 32'hFFFFFFFF, IMM_I, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0);
      wait_accept("full1");
      set_in(32'h123450B7, 8'h52, 32'h12345000, IMM_U, 1'b0, 1'b1,
             64'h0000000012345000, IMM_U, 1'b0);
      wait_accept("full2");
      set_in(32'hFE112E23, 8'h53, 32'hFFFFFFFC, IMM_S, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFC, IMM_S, 1'b0);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i  = 1'b0;
      in_valid = 1'b0;
      check("flush_full_out_valid32", {63'b0, r32_out_valid}, 64'd0);
      check("flush_full_out_valid64", {63'b0, r64_out_valid}, 64'd0);
      check("flush_full_in_ready", {63'b0, r32_in_ready}, 64'd1);

      // Flush while an input is accepted in the same cycle: it is discarded too
      set_in(32'h008000EF, 8'h54, 32'd8, IMM_J, 1'b0, 1'b1,
             64'd8, IMM_J, 1'b0);
      wait_accept("pre_flush");
      set_in(32'h4030D093, 8'h55, 32'd3, IMM_ISH, 1'b0, 1'b1,
             64'd3, IMM_ISH, 1'b0);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i  = 1'b0;
      in_valid = 1'b0;
      check("flush_accept_out_valid", {63'b0, r32_out_valid}, 64'd0);
      check("flush_accept_in_ready", {63'b0, r32_in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("flush_nothing_emerges", {63'b0, r32_out_valid | r64_out_valid}, 64'd0);
      set_in(32'hFFF00093, 8'h56, 32'hFFFFFFFF, IMM_I, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0);
      wait_accept("post_flush");
      in_valid = 1'b0;
      drain("post_flush");

      // Asynchronous reset mid-operation drops entries immediately
      out_ready = 1'b0;
      set_in(32'h123450B7, 8'h61, 32'h12345000, IMM_U, 1'b0, 1'b1,
             64'h0000000012345000, IMM_U, 1'b0);
      wait_accept("pre_rst1");
      set_in(32'hFE000EE3, 8'h62, 32'hFFFFFFFC, IMM_B, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFC, IMM_B, 1'b0);
      wait_accept("pre_rst2");
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", {63'b0, r32_out_valid}, 64'd0);
      check("async_rst_in_ready", {63'b0, r32_in_ready}, 64'd1);
      check("async_rst_out_tag", {56'b0, r64_out_tag}, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("after_rst_out_valid", {63'b0, r32_out_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
